// File: rtl/snn_noc_pkg.sv
// rtl/snn_noc_pkg.sv - NoC packet type codes, field positions, PE address table and packet builder
package snn_noc_pkg;

  localparam logic [1:0] PKT_IFMAP  = 2'b00;
  localparam logic [1:0] PKT_FILTER = 2'b01;
  localparam logic [1:0] PKT_PSUM   = 2'b10;

  localparam int SRC_MSB   = 63;
  localparam int SRC_LSB   = 60;
  localparam int DST_MSB   = 59;
  localparam int DST_LSB   = 56;
  localparam int TYPE_MSB  = 55;
  localparam int TYPE_LSB  = 54;
  localparam int PAYLOAD_W = 40;

  // Node addresses of the diagonal PE chain, entry i belongs to PE i
  localparam int PE_COUNT = 5;
  localparam logic [PE_COUNT-1:0][3:0] PE_ADDR = {4'b1001, 4'b0011, 4'b0010, 4'b0001, 4'b0000};

  // Out-of-range indices map to the last PE, which forwards down the chain
  function automatic logic [3:0] pe_addr(input int unsigned idx);
    logic [2:0] i3;
    i3 = idx[2:0];
    return (idx < PE_COUNT) ? PE_ADDR[i3] : PE_ADDR[PE_COUNT-1];
  endfunction

  // Bits between the type field and the payload are always zero
  function automatic logic [63:0] build_packet(input logic [3:0] src,
                                               input logic [3:0] dst,
                                               input logic [1:0] ptype,
                                               input logic [PAYLOAD_W-1:0] payload);
    logic [63:0] p;
    p = '0;
    p[SRC_MSB:SRC_LSB]   = src;
    p[DST_MSB:DST_LSB]   = dst;
    p[TYPE_MSB:TYPE_LSB] = ptype;
    p[PAYLOAD_W-1:0]     = payload;
    return p;
  endfunction

endpackage

// File: rtl/pe_credit_counter.sv
// rtl/pe_credit_counter.sv - saturating ifmap credit counter with sticky overflow flag
module pe_credit_counter #(
  parameter int INIT_CREDITS = 1,
  parameter int MAX_CREDITS  = 4,
  parameter int CW           = $clog2(MAX_CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          overflow
);

  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  // Simultaneous inc and dec cancel; inc at the ceiling is dropped and flagged
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (inc && !dec) begin
      if (count_q == CW'(MAX_CREDITS)) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (dec && !inc) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Credit and overflow registers; only reset restores the initial credit
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= CW'(INIT_CREDITS);
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/pe_load_packetizer.sv
// rtl/pe_load_packetizer.sv - reads filter then ifmap rows and emits one credit-gated NoC packet per row
module pe_load_packetizer
  import snn_noc_pkg::*;
#(
  parameter int                    PACKET_WIDTH  = 64,
  parameter int                    ADDR_WIDTH    = 4,
  parameter int                    FILTER_LENGTH = 40,
  parameter int                    IFMAP_LENGTH  = 25,
  parameter int                    NUM_PE        = 5,
  parameter int                    IFMAP_ROWS    = 25,
  parameter logic [ADDR_WIDTH-1:0] SRC_ADDR      = 4'b1110,
  parameter int                    INIT_CREDITS  = 1,
  parameter int                    MAX_CREDITS   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          filt_rd_en,
  output logic [$clog2(NUM_PE)-1:0]     filt_rd_addr,
  input  logic [FILTER_LENGTH-1:0]      filt_rd_data,
  output logic                          ifmap_rd_en,
  output logic [$clog2(IFMAP_ROWS)-1:0] ifmap_rd_addr,
  input  logic [IFMAP_LENGTH-1:0]       ifmap_rd_data,
  input  logic                          credit_return,
  output logic                          credit_overflow,
  output logic                          pkt_valid,
  input  logic                          pkt_ready,
  output logic [PACKET_WIDTH-1:0]       pkt_data
);

  localparam int FA_W  = $clog2(NUM_PE);
  localparam int IA_W  = $clog2(IFMAP_ROWS);
  localparam int ROW_W = (IA_W > FA_W) ? IA_W : FA_W;
  localparam int CR_W  = $clog2(MAX_CREDITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_F_RD, S_F_SEND, S_I_CR, S_I_RD, S_I_SEND, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic                   fresh_q, fresh_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic                   consume;
  logic [CR_W-1:0]        credits;
  logic [PAYLOAD_W-1:0]   live_payload;
  logic [3:0]             dst;
  logic [1:0]             ptype;

  pe_credit_counter #(
    .INIT_CREDITS(INIT_CREDITS),
    .MAX_CREDITS (MAX_CREDITS),
    .CW          (CR_W)
  ) u_credits (
    .clk     (clk),
    .rst     (rst),
    .inc     (credit_return),
    .dec     (consume),
    .count   (credits),
    .overflow(credit_overflow)
  );

  // Sequencer: one read cycle then one send phase per row, ifmap rows wait for a credit
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    busy        = 1'b0;
    done        = 1'b0;
    filt_rd_en  = 1'b0;
    ifmap_rd_en = 1'b0;
    pkt_valid   = 1'b0;
    consume     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_F_RD;
          row_d   = '0;
        end
      end
      S_F_RD: begin
        busy       = 1'b1;
        filt_rd_en = 1'b1;
        state_d    = S_F_SEND;
      end
      S_F_SEND: begin
        busy      = 1'b1;
        pkt_valid = 1'b1;
        if (pkt_ready) begin
          if (row_q == ROW_W'(NUM_PE - 1)) begin
            row_d   = '0;
            state_d = S_I_CR;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_F_RD;
          end
        end
      end
      S_I_CR: begin
        busy = 1'b1;
        if (credits != '0) begin
          state_d = S_I_RD;
        end
      end
      S_I_RD: begin
        busy        = 1'b1;
        ifmap_rd_en = 1'b1;
        consume     = 1'b1;
        state_d     = S_I_SEND;
      end
      S_I_SEND: begin
        busy      = 1'b1;
        pkt_valid = 1'b1;
        if (pkt_ready) begin
          if (row_q == ROW_W'(IFMAP_ROWS - 1)) begin
            row_d   = '0;
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_I_CR;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory data is only valid the cycle after the read, so it is captured then and replayed while stalled
  always_comb begin
    live_payload = (state_q == S_F_SEND) ? PAYLOAD_W'(filt_rd_data) : PAYLOAD_W'(ifmap_rd_data);
    fresh_d      = filt_rd_en | ifmap_rd_en;
    payload_d    = fresh_q ? live_payload : payload_q;
    ptype        = (state_q == S_F_SEND) ? PKT_FILTER : PKT_IFMAP;
    if (state_q == S_F_SEND || 32'(row_q) < NUM_PE) begin
      dst = pe_addr(32'(row_q));
    end else begin
      dst = pe_addr(NUM_PE - 1);
    end
  end

  // State, row counter and payload hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      fresh_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      fresh_q   <= fresh_d;
      payload_q <= payload_d;
    end
  end

  assign filt_rd_addr  = filt_rd_en ? row_q[FA_W-1:0] : '0;
  assign ifmap_rd_addr = ifmap_rd_en ? row_q[IA_W-1:0] : '0;
  assign pkt_data      = pkt_valid ? PACKET_WIDTH'(build_packet(SRC_ADDR, dst, ptype, payload_d)) : '0;

endmodule
